// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one line-fill memory port between I-cache and D-cache
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
    input  logic                  i_dfp_read,
    output logic [LINE_WIDTH-1:0] i_dfp_rdata,
    output logic [ADDR_WIDTH-1:0] i_dfp_raddr,
    output logic                  i_dfp_resp,
    input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
    input  logic                  d_dfp_read,
    input  logic                  d_dfp_write,
    input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
    output logic [LINE_WIDTH-1:0] d_dfp_rdata,
    output logic [ADDR_WIDTH-1:0] d_dfp_raddr,
    output logic                  d_dfp_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic                  mem_resp,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(5'h1f);

    state_t state;
    logic   rr_last_d;
    logic   i_req;
    logic   d_req;
    logic   grant_d;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        i_req   = i_dfp_read;
        d_req   = d_dfp_read | d_dfp_write;
        grant_d = d_req && (!i_req || !rr_last_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_last_d <= 1'b0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_BUSY;
                        rr_last_d <= 1'b1;
                        mem_addr  <= d_dfp_addr & ~LINE_MASK;
                        mem_write <= d_dfp_write;
                        mem_read  <= !d_dfp_write;
                        mem_wdata <= d_dfp_wdata;
                    end else if (i_req) begin
                        state     <= I_BUSY;
                        rr_last_d <= 1'b0;
                        mem_addr  <= i_dfp_addr & ~LINE_MASK;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is routed straight through so the owner sees it in the mem_resp cycle.
    always_comb begin
        busy        = (state != IDLE);
        i_dfp_resp  = (state == I_BUSY) && mem_resp;
        d_dfp_resp  = (state == D_BUSY) && mem_resp;
        i_dfp_rdata = (state == I_BUSY) ? mem_rdata : '0;
        i_dfp_raddr = (state == I_BUSY) ? mem_raddr : '0;
        d_dfp_rdata = (state == D_BUSY) ? mem_rdata : '0;
        d_dfp_raddr = (state == D_BUSY) ? mem_raddr : '0;
    end

    a_mem_op_excl: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));
    a_resp_excl:   assert property (@(posedge clk) disable iff (!rst) !(i_dfp_resp && d_dfp_resp));
    a_d_rw_excl:   assert property (@(posedge clk) disable iff (!rst) !(d_dfp_read && d_dfp_write))
        else $warning("d_dfp_read and d_dfp_write both high; serviced as write-back");

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_dfp_addr;
    logic          i_dfp_read;
    logic [LW-1:0] i_dfp_rdata;
    logic [AW-1:0] i_dfp_raddr;
    logic          i_dfp_resp;
    logic [AW-1:0] d_dfp_addr;
    logic          d_dfp_read;
    logic          d_dfp_write;
    logic [LW-1:0] d_dfp_wdata;
    logic [LW-1:0] d_dfp_rdata;
    logic [AW-1:0] d_dfp_raddr;
    logic          d_dfp_resp;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic [AW-1:0] mem_raddr;
    logic          mem_resp;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
        .i_dfp_rdata(i_dfp_rdata), .i_dfp_raddr(i_dfp_raddr), .i_dfp_resp(i_dfp_resp),
        .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
        .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_raddr(d_dfp_raddr),
        .d_dfp_resp(d_dfp_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_raddr(mem_raddr),
        .mem_resp(mem_resp), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        i_dfp_read = 1'b0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; mem_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, mem_read, mem_write, i_dfp_resp, d_dfp_resp} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy, mem_read, mem_write, i_dfp_resp, d_dfp_resp});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_i_read();
        logic [LW-1:0] a;
        a = {8{32'hA5A5_0001}};
        i_dfp_addr = 32'h0000_1234;
        i_dfp_read = 1'b1;
        n_checks++;
        if (mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_latency: mem_read %b expected 0 before edge", mem_read);
        end
        @(posedge clk); #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_1220 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL i_read_issue: rd %b wr %b addr %h busy %b expected 1 0 00001220 1",
                     mem_read, mem_write, mem_addr, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        mem_rdata  = a;
        mem_raddr  = 32'h0000_1220;
        mem_resp   = 1'b1;
        i_dfp_read = 1'b0;
        #1;
        n_checks++;
        if (i_dfp_resp !== 1'b1 || d_dfp_resp !== 1'b0 || i_dfp_rdata !== a || i_dfp_raddr !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL i_read_resp: iresp %b dresp %b rdata %h raddr %h expected 1 0 %h 00001220",
                     i_dfp_resp, d_dfp_resp, i_dfp_rdata, i_dfp_raddr, a);
        end
        n_checks++;
        if (d_dfp_rdata !== '0 || d_dfp_raddr !== '0) begin
            n_fail++;
            $display("FAIL i_read_nonowner: d rdata %h raddr %h expected 0", d_dfp_rdata, d_dfp_raddr);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || i_dfp_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_idle: busy %b rd %b iresp %b expected 0 0 0", busy, mem_read, i_dfp_resp);
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr;
        logic          exp_d;
        apply_reset();
        i_dfp_addr = 32'h0000_2000;
        d_dfp_addr = 32'h0000_3040;
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        exp_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_addr = exp_d ? 32'h0000_3040 : 32'h0000_2000;
            @(posedge clk); #1;
            n_checks++;
            if (mem_read !== 1'b1 || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rr_grant%0d: rd %b addr %h expected 1 %h", k, mem_read, mem_addr, exp_addr);
            end
            @(posedge clk); #1;
            mem_rdata = {8{32'h0BAD_0000 | k}};
            mem_raddr = exp_addr;
            mem_resp  = 1'b1;
            if (k == 3) begin
                i_dfp_read = 1'b0;
                d_dfp_read = 1'b0;
            end
            #1;
            n_checks++;
            if (d_dfp_resp !== exp_d || i_dfp_resp !== !exp_d) begin
                n_fail++;
                $display("FAIL rr_resp%0d: dresp %b iresp %b expected %b %b",
                         k, d_dfp_resp, i_dfp_resp, exp_d, !exp_d);
            end
            @(posedge clk); #1;
            mem_resp = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_bubble%0d: busy %b rd %b expected 0 0", k, busy, mem_read);
            end
            exp_d = !exp_d;
        end
    endtask

    task automatic test_d_write();
        logic [LW-1:0] w;
        int            bad;
        w = {8{32'hDEAD_BEEF}};
        d_dfp_addr  = 32'h8000_0040;
        d_dfp_wdata = w;
        d_dfp_write = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h8000_0040 || mem_wdata !== w) begin
            n_fail++;
            $display("FAIL d_write_issue: wr %b rd %b addr %h wdata %h", mem_write, mem_read, mem_addr, mem_wdata);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            d_dfp_wdata = ~d_dfp_wdata;
            d_dfp_addr  = d_dfp_addr + 32'h20;
            @(posedge clk); #1;
            if (mem_wdata !== w || mem_write !== 1'b1 || mem_addr !== 32'h8000_0040) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL d_write_hold: %0d unstable cycles expected 0", bad);
        end
        mem_raddr   = 32'h8000_0040;
        mem_resp    = 1'b1;
        d_dfp_write = 1'b0;
        #1;
        n_checks++;
        if (d_dfp_resp !== 1'b1 || i_dfp_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL d_write_resp: dresp %b iresp %b expected 1 0", d_dfp_resp, i_dfp_resp);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        n_checks++;
        if (mem_write !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL d_write_done: wr %b busy %b expected 0 0", mem_write, busy);
        end
    endtask

    task automatic test_async_reset();
        logic [LW-1:0] b;
        b = {8{32'h1357_9BDF}};
        d_dfp_addr = 32'h0000_3000;
        d_dfp_read = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: busy %b rd %b expected 1 1", busy, mem_read);
        end
        #2;
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        n_checks++;
        if ({busy, mem_read, mem_write, d_dfp_resp, i_dfp_resp} !== 5'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL areset_async: ctrl %b addr %h expected 00000 0",
                     {busy, mem_read, mem_write, d_dfp_resp, i_dfp_resp}, mem_addr);
        end
        d_dfp_read = 1'b0;
        mem_resp   = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        #1;
        n_checks++;
        if (i_dfp_resp !== 1'b0 || d_dfp_resp !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_stray: iresp %b dresp %b busy %b expected 0 0 0", i_dfp_resp, d_dfp_resp, busy);
        end
        @(posedge clk); #1;
        mem_resp   = 1'b0;
        i_dfp_addr = 32'h0000_5678;
        i_dfp_read = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_idle: busy %b rd %b expected 0 0", busy, mem_read);
        end
        @(posedge clk); #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_5660) begin
            n_fail++;
            $display("FAIL areset_fresh: rd %b addr %h expected 1 00005660", mem_read, mem_addr);
        end
        mem_rdata  = b;
        mem_raddr  = 32'h0000_5660;
        mem_resp   = 1'b1;
        i_dfp_read = 1'b0;
        #1;
        n_checks++;
        if (i_dfp_resp !== 1'b1 || i_dfp_rdata !== b) begin
            n_fail++;
            $display("FAIL areset_fresh_resp: iresp %b rdata %h expected 1 %h", i_dfp_resp, i_dfp_rdata, b);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   pend;
        bit   owner_d;
        bit   exp_d;
        int   grants;
        int   resps;
        int   both_bad;
        int   order_bad;
        int   resp_bad;
        apply_reset();
        i_dfp_addr = 32'h0000_1000;
        d_dfp_addr = 32'h0000_2000;
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        pend = 0; exp_d = 1; owner_d = 0; lat = 0;
        grants = 0; resps = 0; both_bad = 0; order_bad = 0; resp_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (mem_read && mem_write) both_bad++;
            if (!pend) begin
                if (mem_read) begin
                    owner_d = (mem_addr == 32'h0000_2000);
                    if (owner_d != exp_d) order_bad++;
                    exp_d  = !owner_d;
                    pend   = 1;
                    lat    = int'($urandom_range(20, 1));
                    grants++;
                end
            end else begin
                lat--;
                if (lat == 0) begin
                    mem_rdata = {8{$urandom}};
                    mem_raddr = mem_addr;
                    mem_resp  = 1'b1;
                    #1;
                    if (d_dfp_resp !== owner_d || i_dfp_resp !== !owner_d) resp_bad++;
                    if (owner_d && d_dfp_rdata !== mem_rdata) resp_bad++;
                    if (!owner_d && i_dfp_raddr !== mem_raddr) resp_bad++;
                    pend = 0;
                    resps++;
                end
            end
        end
        n_checks++;
        if (both_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_rw_excl: %0d cycles with read and write expected 0", both_bad);
        end
        n_checks++;
        if (order_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_alternation: %0d out-of-order grants expected 0", order_bad);
        end
        n_checks++;
        if (resp_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_resp_route: %0d bad responses expected 0", resp_bad);
        end
        n_checks++;
        if (grants != resps + int'(pend) || grants < 40) begin
            n_fail++;
            $display("FAIL b2b_counts: grants %0d resps %0d pending %0d expected grants=resps+pending and >=40",
                     grants, resps, pend);
        end
        apply_reset();
    endtask

    initial begin
        rst = 1'b0;
        i_dfp_addr = '0; i_dfp_read = 1'b0;
        d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
        mem_rdata = '0; mem_raddr = '0; mem_resp = 1'b0;
        test_reset();
        test_i_read();
        test_round_robin();
        test_d_write();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
